// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [4:0] ITER_LAST = 5'd31;

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO, one result bit per cycle (33 cycles busy).
// Works on magnitudes, then applies sign fixup in a final FIX cycle.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);
  import muldiv_pkg::*;

  logic [1:0]  state_q;
  logic [1:0]  op_q;
  logic        sgn1_q, sgn2_q;
  logic [31:0] mag1_q, mag2_q, raw1_q;
  logic [31:0] acc_hi_q, acc_lo_q;
  logic [31:0] hi_q, lo_q;
  logic [4:0]  cnt_q;
  logic        done_q;

  logic        is_mul, is_signed;
  logic        in_s1, in_s2;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic        q_bit;
  logic [31:0] rem_nxt;
  logic [63:0] prod;

  assign is_mul    = ~op_q[1];
  assign is_signed = ~op_q[0];
  assign in_s1     = ~op_i[0] & data1_i[31];
  assign in_s2     = ~op_i[0] & data2_i[31];

  // mag1 is the multiplicand / shifting dividend, mag2 the shifting multiplier / divisor
  assign mul_sum = {1'b0, acc_hi_q} + (mag2_q[0] ? {1'b0, mag1_q} : 33'd0);
  assign rem_sh  = {acc_hi_q, mag1_q[31]};
  assign q_bit   = (rem_sh >= {1'b0, mag2_q});
  assign rem_nxt = q_bit ? (rem_sh[31:0] - mag2_q) : rem_sh[31:0];
  assign prod    = neg64({acc_hi_q, acc_lo_q}, is_signed & (sgn1_q ^ sgn2_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      mag1_q   <= '0;
      mag2_q   <= '0;
      raw1_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              op_q     <= op_i;
              sgn1_q   <= in_s1;
              sgn2_q   <= in_s2;
              mag1_q   <= neg32(data1_i, in_s1);
              mag2_q   <= neg32(data2_i, in_s2);
              raw1_q   <= data1_i;
              acc_hi_q <= '0;
              acc_lo_q <= '0;
              cnt_q    <= '0;
              state_q  <= S_RUN;
            end else begin
              if (mthi_i) hi_q <= wdata_i;
              if (mtlo_i) lo_q <= wdata_i;
            end
          end
          S_RUN: begin
            if (is_mul) begin
              {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[31:1]};
              mag2_q               <= mag2_q >> 1;
            end else begin
              acc_hi_q <= rem_nxt;
              acc_lo_q <= {acc_lo_q[30:0], q_bit};
              mag1_q   <= mag1_q << 1;
            end
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == ITER_LAST) state_q <= S_FIX;
          end
          S_FIX: begin
            if (is_mul) begin
              {hi_q, lo_q} <= prod;
            end else if (mag2_q == '0) begin
              // divide by zero reports the raw dividend, no sign fixup
              hi_q <= raw1_q;
              lo_q <= '1;
            end else begin
              hi_q <= neg32(acc_hi_q, is_signed & sgn1_q);
              lo_q <= neg32(acc_lo_q, is_signed & (sgn1_q ^ sgn2_q));
            end
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: arithmetic corners, latency, flush, reset and MTHI/MTLO priority.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] data1 = '0, data2 = '0;
  logic        flush = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .data1_i(data1), .data2_i(data2), .flush_i(flush),
    .mthi_i(mthi), .mtlo_i(mtlo), .wdata_i(wdata),
    .hi_o(hi), .lo_o(lo), .busy_o(busy), .done_o(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; data1 = a; data2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    launch(o, a, b);
    wait_idle(cyc);
    chk({tag, ".cyc"}, 64'(cyc), 64'd33);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int cyc;
    logic seen;

    repeat (3) @(negedge clk);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    rst = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    chk("multu_max.pulse", 64'(done), 64'd0);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negdvs", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_zero", 2'b11, 32'h64, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div_zero", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("divu_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

    @(negedge clk);
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mt.hi", 64'(hi), 64'h1234);
    chk("mt.lo", 64'(lo), 64'h5678);

    launch(2'b01, 32'd2, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("flush.done", 64'(seen), 64'd0);
    chk("flush.hi", 64'(hi), 64'h1234);
    chk("flush.lo", 64'(lo), 64'h5678);

    launch(2'b01, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b11; data1 = 32'd99; data2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    wait_idle(cyc);
    chk("restart.cyc", 64'(cyc), 64'd27);
    chk("restart.done", 64'(done), 64'd1);
    chk("restart.hi", 64'(hi), 64'd0);
    chk("restart.lo", 64'(lo), 64'd30);

    launch(2'b11, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.hi", 64'(hi), 64'd0);
    chk("midrst.lo", 64'(lo), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    run_op("divu_after_rst", 2'b11, 32'd1000, 32'd3, 32'd1, 32'd333);

    @(negedge clk);
    start = 1'b1; op = 2'b01; data1 = 32'd2; data2 = 32'd3;
    mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    chk("st_mtlo.lo0", 64'(lo), 64'd333);
    chk("st_mtlo.busy", 64'(busy), 64'd1);
    wait_idle(cyc);
    chk("st_mtlo.hi", 64'(hi), 64'd0);
    chk("st_mtlo.lo", 64'(lo), 64'd6);

    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; data1 = 32'd4; data2 = 32'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_idle.busy", 64'(busy), 64'd0);

    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt_both.hi", 64'(hi), 64'hCAFE);
    chk("mt_both.lo", 64'(lo), 64'hCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
